// File: rtl/fsm_link_pkg.sv
// Shared types for the linked initiator/responder FSM pair.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package fsm_link_pkg;

    // Responder states, one-hot so an illegal encoding is easy to spot.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_COUNT  = 4'b0010,
        ST_RDY    = 4'b0100,
        ST_LINKED = 4'b1000
    } state_t;

    // Initiator states; the initiator FSM lives beside the responder.
    typedef enum logic [1:0] {
        INI_IDLE  = 2'd0,
        INI_START = 2'd1,
        INI_HOLD  = 2'd2,
        INI_XFER  = 2'd3
    } ini_state_t;

    // Responder Moore output encoding, ordered {BUSY, READY, LINK}.
    localparam logic [2:0] OUT_IDLE   = 3'b000;
    localparam logic [2:0] OUT_COUNT  = 3'b100;
    localparam logic [2:0] OUT_RDY    = 3'b010;
    localparam logic [2:0] OUT_LINKED = 3'b011;

    function automatic logic [2:0] out_enc(input state_t s);
        logic [2:0] o;
        o = OUT_IDLE;
        case (s)
            ST_COUNT:  o = OUT_COUNT;
            ST_RDY:    o = OUT_RDY;
            ST_LINKED: o = OUT_LINKED;
            default:   o = OUT_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable W-bit down-counter with a registered-count one-detect flag.
// Latency: load/clr/decrement take effect on the next CLK edge; one is a decode of cnt.
// Backpressure: none; clr beats load beats en, and decrement stops at zero.
// Ports: CLK, N_RESET (async active-low), load/clr/en controls, d load value,
//        one (cnt == 1), cnt (current count).
module link_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         load,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic         one,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= d;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign one = (cnt == W'(1));

endmodule

// File: rtl/fsm_responder.sv
// Responder FSM: counts DELAY cycles after START, raises READY, then tracks LINK time.
// Latency: READY rises D cycles after the START edge (same edge for D=0); outputs are registered.
// Backpressure: none; RESET returns to IDLE, stray STARTs set a sticky ERR.
// Ports: CLK, N_RESET (async active-low), RESET/START/Y from the initiator,
//        DELAY countdown length; READY/BUSY/LINK state outputs, ERR, LINK_CNT.
module fsm_responder
    import fsm_link_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         RESET,
    input  logic         START,
    input  logic         Y,
    input  logic [W-1:0] DELAY,
    output logic         READY,
    output logic         BUSY,
    output logic         LINK,
    output logic         ERR,
    output logic [W-1:0] LINK_CNT
);

    state_t         state;
    state_t         nxt;
    logic           t_load;
    logic           t_clr;
    logic           t_en;
    logic           t_one;
    logic [W-1:0]   t_cnt;
    logic           go_rdy;
    logic           err_set;

    link_timer #(.W(W)) u_timer (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .load    (t_load),
        .clr     (t_clr),
        .en      (t_en),
        .d       (DELAY),
        .one     (t_one),
        .cnt     (t_cnt)
    );

    // A zero count inside COUNT cannot arise from a legal load, but leaving
    // on it too keeps the FSM from sticking in COUNT forever.
    assign go_rdy = t_one || (t_cnt == '0);

    always_comb begin
        nxt    = ST_IDLE;
        t_load = 1'b0;
        t_clr  = 1'b0;
        t_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!RESET && START) begin
                    if (DELAY != '0) begin
                        nxt    = ST_COUNT;
                        t_load = 1'b1;
                    end else begin
                        nxt = ST_RDY;
                    end
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (RESET) begin
                    nxt   = ST_IDLE;
                    t_clr = 1'b1;
                end else if (go_rdy) begin
                    nxt  = ST_RDY;
                    t_en = 1'b1;
                end else begin
                    nxt  = ST_COUNT;
                    t_en = 1'b1;
                end
            end
            ST_RDY: begin
                if (RESET)  nxt = ST_IDLE;
                else if (Y) nxt = ST_LINKED;
                else        nxt = ST_RDY;
            end
            ST_LINKED: begin
                if (RESET) nxt = ST_IDLE;
                else       nxt = ST_LINKED;
            end
            default: begin
                nxt   = ST_IDLE;
                t_clr = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state               <= ST_IDLE;
            {BUSY, READY, LINK} <= OUT_IDLE;
        end else begin
            state               <= nxt;
            {BUSY, READY, LINK} <= out_enc(nxt);
        end
    end

    // START anywhere but IDLE is a protocol violation, whatever RESET does.
    assign err_set = START && ((state == ST_COUNT) || (state == ST_RDY) ||
                               (state == ST_LINKED));

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            ERR <= 1'b0;
        end else if (err_set) begin
            ERR <= 1'b1;
        end
    end

    // LINK_CNT is cleared on entry to LINKED and otherwise holds, so the
    // last link duration stays readable after the link drops.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            LINK_CNT <= '0;
        end else if ((state == ST_RDY) && !RESET && Y) begin
            LINK_CNT <= '0;
        end else if ((state == ST_LINKED) && !RESET && (LINK_CNT != '1)) begin
            LINK_CNT <= LINK_CNT + W'(1);
        end
    end

endmodule

// File: tb/tb_fsm_responder.sv
// Directed bench for fsm_responder: W=8 and W=4 instances driven in lockstep.
// Latency: inputs change 1ns after a rising edge; outputs sampled at the same point.
// Backpressure: n/a.
module tb_fsm_responder;

    logic       clk;
    logic       n_reset;
    logic       reset;
    logic       start;
    logic       y;
    logic [7:0] delay;

    logic       ready8, busy8, link8, err8;
    logic [7:0] lcnt8;
    logic       ready4, busy4, link4, err4;
    logic [3:0] lcnt4;

    int n_chk  = 0;
    int n_pass = 0;

    fsm_responder #(.W(8)) u8 (
        .CLK(clk), .N_RESET(n_reset), .RESET(reset), .START(start), .Y(y),
        .DELAY(delay), .READY(ready8), .BUSY(busy8), .LINK(link8),
        .ERR(err8), .LINK_CNT(lcnt8)
    );

    fsm_responder #(.W(4)) u4 (
        .CLK(clk), .N_RESET(n_reset), .RESET(reset), .START(start), .Y(y),
        .DELAY(delay[3:0]), .READY(ready4), .BUSY(busy4), .LINK(link4),
        .ERR(err4), .LINK_CNT(lcnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        n_reset = 1'b0;
        reset   = 1'b0;
        start   = 1'b0;
        y       = 1'b0;
        delay   = 8'd0;

        // Reset state
        #2;
        check("rst_ready", ready8, 0);
        check("rst_busy",  busy8,  0);
        check("rst_link",  link8,  0);
        check("rst_err",   err8,   0);
        check("rst_lcnt",  lcnt8,  0);
        check("rst_lcnt4", lcnt4,  0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tick();

        // DELAY=5: BUSY five cycles, then READY held, then link counting
        delay = 8'd5; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("a_busy",   busy8,  1);
            check("a_rdy_lo", ready8, 0);
            tick();
        end
        check("a_ready",     ready8, 1);
        check("a_busy_done", busy8,  0);
        tick();
        check("a_ready_hold", ready8, 1);
        y = 1'b1; tick(); y = 1'b0;
        check("a_link",       link8,  1);
        check("a_link_ready", ready8, 1);
        check("a_lcnt0",      lcnt8,  0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("a_lcnt", lcnt8, i);
        end

        // Asynchronous N_RESET mid-LINKED, observed before the next edge
        #2 n_reset = 1'b0;
        #1;
        check("ar_ready", ready8, 0);
        check("ar_link",  link8,  0);
        check("ar_busy",  busy8,  0);
        check("ar_lcnt",  lcnt8,  0);
        #2 n_reset = 1'b1;
        tick();
        check("ar_idle", ready8, 0);

        // DELAY=0 and DELAY=1
        delay = 8'd0; start = 1'b1; tick(); start = 1'b0;
        check("b0_ready", ready8, 1);
        check("b0_busy",  busy8,  0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("b0_idle", ready8, 0);
        delay = 8'd1; start = 1'b1; tick(); start = 1'b0;
        check("b1_busy",   busy8,  1);
        check("b1_rdy_lo", ready8, 0);
        tick();
        check("b1_ready", ready8, 1);
        check("b1_idle",  busy8,  0);
        reset = 1'b1; tick(); reset = 1'b0;

        // DELAY=10 aborted by RESET after four counting cycles
        delay = 8'd10; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        check("c_busy", busy8, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("c_busy_drop", busy8,  0);
        check("c_ready",     ready8, 0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (ready8 || busy8) seen = 1'b1;
        end
        check("c_quiet", seen, 0);
        check("c_err",   err8, 0);

        // Second START during COUNT: timing unchanged, ERR sticky
        delay = 8'd6; start = 1'b1; tick(); start = 1'b0;
        tick();
        delay = 8'd2; start = 1'b1; tick(); start = 1'b0; delay = 8'd6;
        check("d_err",  err8,  1);
        check("d_busy", busy8, 1);
        tick(); tick(); tick();
        check("d_ready_lo", ready8, 0);
        check("d_busy_hi",  busy8,  1);
        tick();
        check("d_ready",   ready8, 1);
        check("d_busy_lo", busy8,  0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("d_err_sticky", err8,   1);
        check("d_idle",       ready8, 0);

        // LINK_CNT saturation on the W=4 instance
        delay = 8'd0; start = 1'b1; tick(); start = 1'b0;
        y = 1'b1; tick(); y = 1'b0;
        check("e_link4",  link4, 1);
        check("e_lcnt4_0", lcnt4, 0);
        repeat (14) tick();
        check("e_lcnt4_14", lcnt4, 14);
        repeat (6) tick();
        check("e_lcnt4_sat", lcnt4, 15);
        check("e_lcnt8_20",  lcnt8, 20);
        reset = 1'b1; tick(); reset = 1'b0;
        check("e_link_off", link8, 0);
        check("e_hold4",    lcnt4, 15);
        check("e_hold8",    lcnt8, 20);

        // RESET and Y together in RDY: RESET wins, LINK_CNT untouched
        delay = 8'd0; start = 1'b1; tick(); start = 1'b0;
        check("f_ready", ready8, 1);
        reset = 1'b1; y = 1'b1; tick(); reset = 1'b0; y = 1'b0;
        check("f_link",  link8,  0);
        check("f_ready_lo", ready8, 0);
        check("f_lcnt8", lcnt8,  20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fsm_responder.md
# fsm_responder

Responder end of the linked state machine pair. It consumes the initiator's RESET/START/Y control outputs, runs a programmable countdown after each START, and then returns READY to release the initiator from its hold state. It also tracks protocol misuse and how long the link stays engaged. The block sits beside the initiator FSM in the linked-FSM subsystem, clocked by the same CLK.

## Interface
Parameters:
- W, default 8: width of DELAY, the countdown and LINK_CNT.

Ports:
- CLK, input, 1: clock. Rising edge.
- N_RESET, input, 1: asynchronous, active-low reset.
- RESET, input, 1: initiator's synchronous soft reset. High forces IDLE.
- START, input, 1: initiator's start pulse, nominally 1 cycle.
- Y, input, 1: initiator's data-transfer indication.
- DELAY, input, W: countdown length, sampled only on START acceptance.
- READY, output, 1: responder ready. Moore output.
- BUSY, output, 1: countdown in progress. Moore output.
- LINK, output, 1: link engaged (initiator asserted Y after READY).
- ERR, output, 1: sticky protocol error.
- LINK_CNT, output, W: saturating count of cycles spent in LINKED.

## Operation
- States (one-hot enum): IDLE=1, COUNT=2, RDY=4, LINKED=8. Any illegal encoding goes to IDLE on the next edge.
- Moore outputs {BUSY, READY, LINK}:
  - IDLE: 000
  - COUNT: 100
  - RDY: 010
  - LINKED: 011
- IDLE transitions:
  - RESET=1: stay in IDLE. RESET beats START.
  - START=1, RESET=0, DELAY≠0: go to COUNT and load cnt=DELAY.
  - START=1, RESET=0, DELAY=0: go directly to RDY.
- COUNT transitions:
  - RESET=1: go to IDLE and clear cnt.
  - Otherwise, cnt==1: go to RDY.
  - Otherwise: cnt decrements.
  - START=1 in COUNT: ignored for state purposes; sets ERR.
- RDY transitions:
  - RESET=1: go to IDLE.
  - Y=1: go to LINKED and clear LINK_CNT.
  - START=1 in RDY: sets ERR and stays in RDY.
- LINKED transitions:
  - RESET=1: go to IDLE.
  - Otherwise stay. LINK_CNT increments each cycle and saturates at 2^W−1.
  - START=1 in LINKED: sets ERR.
- Y seen in IDLE or COUNT: no effect.
- ERR is cleared only by N_RESET. RESET does not clear it.
- LINK_CNT holds its value after leaving LINKED, so software can read it. It is cleared on entry to LINKED or by N_RESET.
- DELAY arithmetic is unsigned W-bit. The maximum is 2^W−1 cycles. There is no wrap.

## Timing
- N_RESET low, asynchronously:
  - state = IDLE, cnt = 0.
  - READY = BUSY = LINK = ERR = 0, LINK_CNT = 0.
- Release of N_RESET is synchronised externally. The first active edge after release behaves as from IDLE.
- START accepted at edge k with DELAY=D≥1:
  - BUSY is high for cycles k..k+D−1.
  - READY rises after edge k+D.
  - Latency from START to READY is D cycles.
- D=0: READY rises after edge k, one cycle earlier than D=1.
- READY → initiator → Y: the initiator's Y lags READY by at least one cycle. The responder accepts Y in the same cycle it is sampled in RDY.
- RESET mid-count: READY never asserts. BUSY drops after the same edge.
- RESET and Y high together in RDY: RESET wins, next state is IDLE, LINK_CNT is unchanged.
- All outputs are registered-state decodes. There are no combinational paths from inputs to outputs.

## Structure
- Shared package fsm_link_pkg:
  - responder state_t enum with the one-hot values above.
  - output-encoding constants.
  - This is the same package that holds the initiator's state type.
- Sub-module link_timer holds the W-bit loadable down-counter with a zero/one-detect flag:
  - ports CLK, N_RESET, load, clr, en, d, one, cnt.
  - fsm_responder instantiates it once.
- LINK_CNT saturating counter and the ERR flop live in fsm_responder.

## Test plan
- N_RESET pulse mid-LINKED → all outputs 0 immediately, asynchronously, without waiting for CLK.
- RESET=0, START pulse with DELAY=5 → BUSY high for 5 cycles, READY high on the 6th cycle after START and held. Then Y=1 → LINK=1, LINK_CNT counts 1,2,3…
- DELAY=0 START → READY one cycle after START, BUSY never high. DELAY=1 → BUSY one cycle, READY after 2.
- DELAY=10, RESET asserted at count 4 → IDLE next edge, READY never asserts, ERR stays 0.
- Second START during COUNT (DELAY=6) → READY timing is still 6 cycles from the first START, ERR=1 and persists through a later RESET.
- W=4, hold LINKED for 20 cycles → LINK_CNT saturates at 15. Then RESET → IDLE with LINK_CNT=15 held.
